// File: rtl/chan_arb_mux.sv
// rtl/chan_arb_mux.sv - N-channel valid/ready arbiter with a one-entry registered output
module chan_arb_mux #(
    parameter int WIDTH = 8,
    parameter int N_CH  = 4,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              mode,
    input  logic [SEL_W-1:0]        sel_i,
    input  logic [N_CH-1:0]         in_valid,
    input  logic [N_CH*WIDTH-1:0]   in_data,
    output logic [N_CH-1:0]         in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
    input  logic                    out_ready
);

    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out_data;
    logic [SEL_W-1:0]   r_out_ch;
    logic [SEL_W-1:0]   r_rr_ptr;

    logic               w_take;
    logic               w_found;
    logic [SEL_W-1:0]   w_grant;
    logic [N_CH-1:0]    w_ready;

    assign w_take = ~r_out_valid | out_ready;

    always_comb begin
        int idx;
        w_found = 1'b0;
        w_grant = '0;
        idx     = 0;
        case (mode)
            2'b00: begin
                // Search starts at the pointer and wraps once around all channels.
                for (int i = 0; i < N_CH; i++) begin
                    idx = int'(r_rr_ptr) + i;
                    if (idx >= N_CH) idx = idx - N_CH;
                    if (!w_found && in_valid[idx]) begin
                        w_found = 1'b1;
                        w_grant = SEL_W'(idx);
                    end
                end
            end
            2'b10: begin
                if (int'(sel_i) < N_CH) begin
                    if (in_valid[sel_i]) begin
                        w_found = 1'b1;
                        w_grant = sel_i;
                    end
                end
            end
            default: begin
                for (int i = 0; i < N_CH; i++) begin
                    if (!w_found && in_valid[i]) begin
                        w_found = 1'b1;
                        w_grant = SEL_W'(i);
                    end
                end
            end
        endcase
    end

    always_comb begin
        w_ready = '0;
        if (rst_n && w_take && w_found) w_ready[w_grant] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_rr_ptr    <= '0;
        end else if (w_take) begin
            r_out_valid <= w_found;
            if (w_found) begin
                r_out_data <= in_data[int'(w_grant)*WIDTH +: WIDTH];
                r_out_ch   <= w_grant;
                if (int'(w_grant) == N_CH-1) r_rr_ptr <= '0;
                else                         r_rr_ptr <= w_grant + SEL_W'(1);
            end
        end
    end

    assign in_ready  = w_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_chan_arb_mux.sv
// tb/tb_chan_arb_mux.sv - randomized and directed checks of chan_arb_mux against a behavioural model
module tb_chan_arb_mux;
    localparam int WIDTH = 8;
    localparam int N_CH  = 4;
    localparam int SEL_W = $clog2(N_CH);

    logic                  clk;
    logic                  rst_n;
    logic [1:0]            mode;
    logic [SEL_W-1:0]      sel_i;
    logic [N_CH-1:0]       in_valid;
    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_ready;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic [SEL_W-1:0]      out_ch;
    logic                  out_ready;

    int checks = 0;
    int errors = 0;

    chan_arb_mux #(.WIDTH(WIDTH), .N_CH(N_CH)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel_i(sel_i),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: the held word and the round-robin start point.
    int             m_valid = 0;
    int             m_data  = 0;
    int             m_ch    = 0;
    int             m_ptr   = 0;

    function automatic int model_grant();
        int k;
        if (mode == 2'b00) begin
            for (int i = 0; i < N_CH; i++) begin
                k = (m_ptr + i) % N_CH;
                if (in_valid[k]) return k;
            end
            return -1;
        end
        if (mode == 2'b10) begin
            if (int'(sel_i) < N_CH && in_valid[sel_i]) return int'(sel_i);
            return -1;
        end
        for (int i = 0; i < N_CH; i++) if (in_valid[i]) return i;
        return -1;
    endfunction

    function automatic int model_ready();
        int g;
        g = model_grant();
        if (rst_n !== 1'b1) return 0;
        if (!(m_valid == 0 || out_ready)) return 0;
        if (g < 0) return 0;
        return 1 << g;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        int g;
        if (!rst_n) begin
            m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 0;
        end else if (m_valid == 0 || out_ready) begin
            g = model_grant();
            if (g >= 0) begin
                m_valid = 1;
                m_data  = int'(in_data[g*WIDTH +: WIDTH]);
                m_ch    = g;
                m_ptr   = (g + 1) % N_CH;
            end else begin
                m_valid = 0;
            end
        end
    end

    always @(negedge clk) begin
        #1;
        chk("model_out_valid", int'(out_valid), m_valid);
        chk("model_out_data",  int'(out_data),  m_data);
        chk("model_out_ch",    int'(out_ch),    m_ch);
        chk("model_in_ready",  int'(in_ready),  model_ready());
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0; mode = 2'b00; sel_i = '0; out_ready = 1'b1;
        in_valid = 4'hF;
        in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

        // Reset with every channel requesting
        tick();
        @(negedge clk); #2;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_ch", int'(out_ch), 0);

        // Round-robin over all-valid channels
        tick();
        rst_n = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #2;
            chk("rr_out_ch", int'(out_ch), i % 4);
            chk("rr_out_data", int'(out_data), 8'hA0 + (i % 4));
            chk("rr_out_valid", int'(out_valid), 1);
        end

        // Fixed priority starves ch3 while ch1 is valid
        tick();
        mode = 2'b01; in_valid = 4'b1010;
        @(posedge clk);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #2;
            chk("fix_out_ch", int'(out_ch), 1);
            chk("fix_in_ready", int'(in_ready), 4'b0010);
        end

        // Manual select of an idle channel, then of a valid one
        tick();
        mode = 2'b10; sel_i = 2'd2; in_valid = 4'b0011;
        @(posedge clk);
        @(negedge clk); #2;
        chk("man_none_ready", int'(in_ready), 0);
        chk("man_none_valid", int'(out_valid), 0);
        tick();
        in_valid = 4'b0111;
        @(posedge clk);
        @(negedge clk); #2;
        chk("man_out_valid", int'(out_valid), 1);
        chk("man_out_ch", int'(out_ch), 2);
        chk("man_out_data", int'(out_data), 8'hA2);

        // Backpressure holds the word and blocks all channels
        tick();
        out_ready = 1'b0; mode = 2'b01; in_valid = 4'b0011;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #2;
            chk("bp_out_data", int'(out_data), 8'hA2);
            chk("bp_out_ch", int'(out_ch), 2);
            chk("bp_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", int'(in_ready), 4'b0001);
        @(negedge clk); #2;
        chk("bp_reload_ch", int'(out_ch), 0);
        chk("bp_reload_valid", int'(out_valid), 1);

        // Mid-stream reset with the pointer at 3
        mode = 2'b00; in_valid = 4'b0100;
        tick();
        rst_n = 1'b0; in_valid = 4'hF;
        @(negedge clk); #2;
        chk("mrst_in_ready", int'(in_ready), 0);
        @(negedge clk); #2;
        chk("mrst_out_valid", int'(out_valid), 0);
        rst_n = 1'b1;
        @(negedge clk); #2;
        chk("mrst_first_ch", int'(out_ch), 0);
        chk("mrst_first_valid", int'(out_valid), 1);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            tick();
            rst_n     = ($urandom_range(0, 60) != 0);
            mode      = 2'($urandom_range(0, 3));
            sel_i     = SEL_W'($urandom_range(0, N_CH - 1));
            in_valid  = N_CH'($urandom);
            in_data   = {$urandom};
            out_ready = ($urandom_range(0, 3) != 0);
        end
        tick();
        @(negedge clk); #3;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
